// File: rtl/rx_lane_arbiter_pkg.sv
// Shared types and default sizing for the phy_rx lane arbiter.
// Arbiter FSM encoding plus the derived widths for the default configuration.
package rx_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BURST_MAX = 4;
  localparam int LANE_W        = $clog2(DEF_NUM_LANES);
  localparam int CNT_W         = $clog2(DEF_BURST_MAX + 1);

endpackage

// File: rtl/rx_lane_arbiter_if.sv
// Lane-side request bundle and downstream byte port of the lane arbiter.
// The slave modport is the arbiter's view; master is the lane/downstream side.
interface rx_lane_arbiter_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8
);
  localparam int LANE_BITS = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES*DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0]        lane_ready;
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [LANE_BITS-1:0]        out_lane;
  logic                        out_ready;

  modport slave (
    input  lane_valid, lane_data, out_ready,
    output lane_ready, out_valid, out_data, out_lane
  );

  modport master (
    output lane_valid, lane_data, out_ready,
    input  lane_ready, out_valid, out_data, out_lane
  );
endinterface

// File: rtl/rx_lane_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, modulo NUM_LANES.
// NUM_LANES is a power of two, so index arithmetic wraps in LANE_BITS naturally.
module rr_pick #(
  parameter  int NUM_LANES = 4,
  localparam int LANE_BITS = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] i_req,
  input  logic [LANE_BITS-1:0] i_ptr,
  output logic [LANE_BITS-1:0] o_pick,
  output logic                 o_any_req
);

  logic [NUM_LANES-1:0] w_rot;
  logic [LANE_BITS-1:0] w_enc;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_rot[i] = i_req[LANE_BITS'(i) + i_ptr];
    end
    // Descending scan leaves the lowest rotated index, i.e. closest to i_ptr.
    w_enc = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = LANE_BITS'(i);
    end
    o_pick    = w_enc + i_ptr;
    o_any_req = |i_req;
  end

endmodule

// File: rtl/rx_lane_arbiter.sv
// Round-robin burst arbiter sharing one byte path among NUM_LANES receive lanes.
// One registered output stage; a grant lasts up to BURST_MAX transferred beats.
module rx_lane_arbiter
  import rx_arb_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  rx_lane_arbiter_if.slave      bus,
  output logic                  busy
);

  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int CNT_BITS  = $clog2(BURST_MAX + 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [LANE_BITS-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [LANE_BITS-1:0] r_owner, w_owner_nxt;
  logic [CNT_BITS-1:0]  r_beat_cnt, w_beat_cnt_nxt;

  logic                 r_vld_p1;
  logic [DATA_W-1:0]    r_data_p1;
  logic [LANE_BITS-1:0] r_lane_p1;

  logic                 w_load;
  logic                 w_any_req;
  logic [LANE_BITS-1:0] w_pick;
  logic                 w_take;
  logic [LANE_BITS-1:0] w_take_lane;
  logic [DATA_W-1:0]    w_take_data;
  logic [NUM_LANES-1:0] w_ready;

  rr_pick #(.NUM_LANES(NUM_LANES)) u_pick (
    .i_req     (bus.lane_valid),
    .i_ptr     (r_rr_ptr),
    .o_pick    (w_pick),
    .o_any_req (w_any_req)
  );

  assign w_load = !r_vld_p1 || bus.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_take         = 1'b0;
    w_take_lane    = r_owner;
    case (r_state)
      IDLE: begin
        if (enable && w_load && w_any_req) begin
          w_take         = 1'b1;
          w_take_lane    = w_pick;
          w_owner_nxt    = w_pick;
          w_beat_cnt_nxt = CNT_BITS'(1);
          if (BURST_MAX > 1) w_state_nxt  = GRANT;
          else               w_rr_ptr_nxt = w_pick + 1'b1;
        end
      end
      GRANT: begin
        // Stalled cycles leave everything untouched so they never count as beats.
        if (w_load) begin
          if (bus.lane_valid[r_owner]) begin
            w_take         = 1'b1;
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            if (w_beat_cnt_nxt == CNT_BITS'(BURST_MAX)) begin
              w_state_nxt  = IDLE;
              w_rr_ptr_nxt = r_owner + 1'b1;
            end
          end else begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = r_owner + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready     = '0;
    w_take_data = bus.lane_data[w_take_lane*DATA_W +: DATA_W];
    if (w_take && !reset) w_ready[w_take_lane] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // ---- stage p1: registered output byte ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_lane_p1 <= '0;
    end else if (w_take) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_take_data;
      r_lane_p1 <= w_take_lane;
    end else if (bus.out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign bus.lane_ready = w_ready;
  assign bus.out_valid  = r_vld_p1;
  assign bus.out_data   = r_data_p1;
  assign bus.out_lane   = r_lane_p1;
  assign busy           = (r_state == GRANT);

endmodule

// File: tb/tb_rx_lane_arbiter.sv
// Directed bench for rx_lane_arbiter (4 lanes, 8-bit bytes, bursts of 4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_rx_lane_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic busy;

  int n_assert = 0;
  int n_fail   = 0;

  rx_lane_arbiter_if #(.NUM_LANES(4), .DATA_W(8)) bus ();

  rx_lane_arbiter #(.NUM_LANES(4), .DATA_W(8), .BURST_MAX(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {28'd0, bus.lane_ready}, {28'd0, exp});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] l, input logic b);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, "_data"},  {24'd0, bus.out_data},  {24'd0, d});
    chk({tag, "_lane"},  {30'd0, bus.out_lane},  {30'd0, l});
    chk({tag, "_busy"},  {31'd0, busy},          {31'd0, b});
  endtask

  task automatic set_lane(input int i, input logic [7:0] d);
    bus.lane_data[i*8 +: 8] = d;
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    bus.lane_valid = '0;
    bus.lane_data  = '0;
    bus.out_ready  = 1'b1;

    // Reset held for three edges, then released with no requests.
    repeat (3) cyc();
    chk("rst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_hold_rdy", {28'd0, bus.lane_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk_out("post_rst", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("post_rst_rdy", {28'd0, bus.lane_ready}, 32'd0);

    // Lane 2 alone: two back-to-back bursts of 4, busy drops between them.
    enable         = 1'b1;
    bus.lane_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      set_lane(2, 8'(8'h10 + k));
      chk_rdy("single_rdy", 4'b0100);
      cyc();
      chk_out("single", 1'b1, 8'(8'h10 + k), 2'd2, (k != 3) && (k != 7));
    end
    bus.lane_valid = 4'b0000;
    chk_rdy("single_end_rdy", 4'b0000);
    cyc();
    chk("single_end_valid", {31'd0, bus.out_valid}, 32'd0);

    // Lane 3 drops valid after one beat: one bubble, pointer wraps to 0.
    bus.lane_valid = 4'b1000;
    set_lane(3, 8'hA0);
    chk_rdy("drop_rdy", 4'b1000);
    cyc();
    chk_out("drop_beat", 1'b1, 8'hA0, 2'd3, 1'b1);
    bus.lane_valid = 4'b0000;
    chk_rdy("drop_bubble_rdy", 4'b0000);
    cyc();
    chk("drop_bubble_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drop_bubble_busy", {31'd0, busy}, 32'd0);

    // Lanes 0 and 3 first, then full contention: lane order 0,1,2,3,0.
    for (int j = 0; j < 20; j++) begin
      int e;
      e = (j / 4) % 4;
      bus.lane_valid = (j == 0) ? 4'b1001 : 4'b1111;
      for (int i = 0; i < 4; i++) set_lane(i, 8'(i * 16 + j));
      chk_rdy("cont_rdy", 4'(1 << e));
      cyc();
      chk_out("cont", 1'b1, 8'(e * 16 + j), 2'(e), (j % 4) != 3);
    end
    bus.lane_valid = 4'b0000;
    chk_rdy("cont_end_rdy", 4'b0000);
    cyc();
    chk("cont_end_valid", {31'd0, bus.out_valid}, 32'd0);

    // Lane 1 burst with 5 stalled cycles after beat 2.
    bus.lane_valid = 4'b0010;
    set_lane(1, 8'h50);
    chk_rdy("bp_rdy1", 4'b0010);
    cyc();
    chk_out("bp_b1", 1'b1, 8'h50, 2'd1, 1'b1);
    set_lane(1, 8'h51);
    chk_rdy("bp_rdy2", 4'b0010);
    cyc();
    chk_out("bp_b2", 1'b1, 8'h51, 2'd1, 1'b1);
    bus.out_ready = 1'b0;
    set_lane(1, 8'h52);
    repeat (5) begin
      chk_rdy("bp_stall_rdy", 4'b0000);
      cyc();
      chk_out("bp_stall", 1'b1, 8'h51, 2'd1, 1'b1);
    end
    bus.out_ready = 1'b1;
    chk_rdy("bp_rdy3", 4'b0010);
    cyc();
    chk_out("bp_b3", 1'b1, 8'h52, 2'd1, 1'b1);
    set_lane(1, 8'h53);
    chk_rdy("bp_rdy4", 4'b0010);
    cyc();
    chk_out("bp_b4", 1'b1, 8'h53, 2'd1, 1'b0);

    // Pointer now at 2: lane 2 wins over 0 and 1; enable falls mid-burst.
    bus.lane_valid = 4'b0111;
    set_lane(0, 8'h70);
    set_lane(1, 8'h71);
    set_lane(2, 8'h60);
    chk_rdy("en_rdy0", 4'b0100);
    cyc();
    chk_out("en_b1", 1'b1, 8'h60, 2'd2, 1'b1);
    enable = 1'b0;
    for (int k = 1; k < 4; k++) begin
      set_lane(2, 8'(8'h60 + k));
      chk_rdy("en_off_rdy", 4'b0100);
      cyc();
      chk_out("en_off", 1'b1, 8'(8'h60 + k), 2'd2, k != 3);
    end
    repeat (3) begin
      chk_rdy("en_block_rdy", 4'b0000);
      cyc();
      chk("en_block_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("en_block_busy", {31'd0, busy}, 32'd0);
    end
    enable = 1'b1;
    chk_rdy("en_on_rdy", 4'b0001);
    cyc();
    chk_out("en_on", 1'b1, 8'h70, 2'd0, 1'b1);

    // Asynchronous reset pulse between edges clears state immediately.
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("async_rst_rdy", {28'd0, bus.lane_ready}, 32'd0);
    bus.lane_valid = 4'b0000;
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_rel_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.lane_valid = 4'b0011;
    set_lane(0, 8'h99);
    chk_rdy("rst_ptr_rdy", 4'b0001);
    cyc();
    chk_out("rst_ptr", 1'b1, 8'h99, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
